// File: rtl/udp_echo_app_filter.sv
// UDP echo tile with handshake on both NoC sides, an optional destination-port
// filter, a payload length limit (oversize packets are drained) and saturating
// echo/drop statistics. Header and metadata are rebuilt with swapped
// addresses. Data flits are forwarded combinationally.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 256
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif

module udp_echo_app_filter #(
    parameter int SRC_X        = -1,
    parameter int SRC_Y        = -1,
    parameter int MAX_DATA_LEN = 1500,
    parameter int FILTER_PORT  = -1,
    parameter int CNT_W        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       noc0_ctovr_udp_app_in_val,
    input  logic [`NOC_DATA_WIDTH-1:0] noc0_ctovr_udp_app_in_data,
    output logic                       udp_app_in_noc0_ctovr_rdy,
    output logic                       udp_app_out_noc0_vrtoc_val,
    output logic [`NOC_DATA_WIDTH-1:0] udp_app_out_noc0_vrtoc_data,
    input  logic                       noc0_vrtoc_udp_app_out_rdy,
    input  logic [`XY_WIDTH-1:0]       src_udp_app_out_dst_x,
    input  logic [`XY_WIDTH-1:0]       src_udp_app_out_dst_y,
    output logic [CNT_W-1:0]           echo_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       busy
);

    localparam int W         = `NOC_DATA_WIDTH;
    localparam int XW        = `XY_WIDTH;
    localparam int MLW       = `MSG_LENGTH_WIDTH;
    localparam int FBW       = 4;
    localparam int HDR_USED  = 4 * XW + 2 * FBW + MLW + 8 + 8 + 16 + 64;
    localparam int META_USED = 32 + 32 + 16 + 16 + 16 + 64;

    localparam logic [FBW-1:0] PKT_IF_FBITS   = 4'b1000;
    localparam logic [7:0]     UDP_TX_SEGMENT = 8'd12;
    localparam logic [XW-1:0]  SRC_X_V        = XW'(SRC_X);
    localparam logic [XW-1:0]  SRC_Y_V        = XW'(SRC_Y);
    localparam logic [31:0]    MAX_LEN_V      = 32'(MAX_DATA_LEN);

    // Header flit layout, most significant field first.
    typedef struct packed {
        logic [XW-1:0]       dst_x;
        logic [XW-1:0]       dst_y;
        logic [FBW-1:0]      dst_fbits;
        logic [MLW-1:0]      msg_len;
        logic [7:0]          msg_type;
        logic [XW-1:0]       src_x;
        logic [XW-1:0]       src_y;
        logic [FBW-1:0]      src_fbits;
        logic [7:0]          metadata_flits;
        logic [15:0]         packet_id;
        logic [63:0]         timestamp;
        logic [W-HDR_USED-1:0] pad;
    } hdr_t;

    // Metadata flit layout, most significant field first.
    typedef struct packed {
        logic [31:0]            src_ip;
        logic [31:0]            dst_ip;
        logic [15:0]            src_port;
        logic [15:0]            dst_port;
        logic [15:0]            data_length;
        logic [63:0]            timestamp;
        logic [W-META_USED-1:0] pad;
    } meta_t;

    typedef enum logic [2:0] {
        RX_HDR, RX_META, TX_HDR, TX_META, PASS, DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [MLW-1:0]   hdr_msg_len_q, hdr_msg_len_d;
    logic [15:0]      hdr_pkt_id_q, hdr_pkt_id_d;
    logic [63:0]      hdr_ts_q, hdr_ts_d;
    logic [31:0]      meta_src_ip_q, meta_src_ip_d;
    logic [31:0]      meta_dst_ip_q, meta_dst_ip_d;
    logic [15:0]      meta_src_port_q, meta_src_port_d;
    logic [15:0]      meta_dst_port_q, meta_dst_port_d;
    logic [15:0]      meta_len_q, meta_len_d;
    logic [63:0]      meta_ts_q, meta_ts_d;
    logic [MLW-1:0]   flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] echo_cnt_q, echo_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    hdr_t           in_hdr, out_hdr;
    meta_t          in_meta, out_meta;
    logic           in_rdy, out_val;
    logic [W-1:0]   out_data;
    logic           in_xfer, out_xfer;
    logic           len_reject, port_reject;
    logic [MLW-1:0] data_flits;
    logic [MLW-1:0] flit_cnt_inc;
    logic           unused_in_fields;

    assign in_hdr       = noc0_ctovr_udp_app_in_data;
    assign in_meta      = noc0_ctovr_udp_app_in_data;
    assign in_xfer      = noc0_ctovr_udp_app_in_val & in_rdy;
    assign out_xfer     = out_val & noc0_vrtoc_udp_app_out_rdy;
    assign data_flits   = (hdr_msg_len_q != '0) ? hdr_msg_len_q - 1'b1 : '0;
    assign flit_cnt_inc = flit_cnt_q + 1'b1;
    assign len_reject   = {16'd0, in_meta.data_length} > MAX_LEN_V;

    // Incoming header fields that are regenerated rather than echoed.
    assign unused_in_fields = ^{in_hdr.dst_x, in_hdr.dst_y, in_hdr.dst_fbits,
                                in_hdr.msg_type, in_hdr.src_x, in_hdr.src_y,
                                in_hdr.src_fbits, in_hdr.metadata_flits,
                                in_hdr.pad, in_meta.pad};

    // The port comparator only exists when a filter port is configured.
    generate
        if (FILTER_PORT == -1) begin : g_no_filter
            assign port_reject = 1'b0;
        end else begin : g_filter
            localparam logic [15:0] FILTER_PORT_V = 16'(FILTER_PORT);
            assign port_reject = (in_meta.dst_port != FILTER_PORT_V);
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake and output flit selection decoded from the current state.
    always_comb begin
        out_hdr                = '0;
        out_hdr.dst_x          = src_udp_app_out_dst_x;
        out_hdr.dst_y          = src_udp_app_out_dst_y;
        out_hdr.dst_fbits      = PKT_IF_FBITS;
        out_hdr.msg_len        = hdr_msg_len_q;
        out_hdr.msg_type       = UDP_TX_SEGMENT;
        out_hdr.src_x          = SRC_X_V;
        out_hdr.src_y          = SRC_Y_V;
        out_hdr.src_fbits      = PKT_IF_FBITS;
        out_hdr.metadata_flits = 8'd1;
        out_hdr.packet_id      = hdr_pkt_id_q;
        out_hdr.timestamp      = hdr_ts_q;
        out_meta               = '0;
        out_meta.src_ip        = meta_dst_ip_q;
        out_meta.dst_ip        = meta_src_ip_q;
        out_meta.src_port      = meta_dst_port_q;
        out_meta.dst_port      = meta_src_port_q;
        out_meta.data_length   = meta_len_q;
        out_meta.timestamp     = meta_ts_q;
        in_rdy                 = 1'b0;
        out_val                = 1'b0;
        out_data               = '0;
        case (state_q)
            RX_HDR, RX_META, DRAIN: in_rdy = 1'b1;
            TX_HDR: begin
                out_val  = 1'b1;
                out_data = out_hdr;
            end
            TX_META: begin
                out_val  = 1'b1;
                out_data = out_meta;
            end
            PASS: begin
                out_val  = noc0_ctovr_udp_app_in_val;
                out_data = noc0_ctovr_udp_app_in_data;
                in_rdy   = noc0_vrtoc_udp_app_out_rdy;
            end
            default: ;
        endcase
    end

    // Next-state, field capture and statistics updates.
    always_comb begin
        state_d         = state_q;
        hdr_msg_len_d   = hdr_msg_len_q;
        hdr_pkt_id_d    = hdr_pkt_id_q;
        hdr_ts_d        = hdr_ts_q;
        meta_src_ip_d   = meta_src_ip_q;
        meta_dst_ip_d   = meta_dst_ip_q;
        meta_src_port_d = meta_src_port_q;
        meta_dst_port_d = meta_dst_port_q;
        meta_len_d      = meta_len_q;
        meta_ts_d       = meta_ts_q;
        flit_cnt_d      = flit_cnt_q;
        echo_cnt_d      = echo_cnt_q;
        drop_cnt_d      = drop_cnt_q;
        case (state_q)
            RX_HDR: if (in_xfer) begin
                hdr_msg_len_d = in_hdr.msg_len;
                hdr_pkt_id_d  = in_hdr.packet_id;
                hdr_ts_d      = in_hdr.timestamp;
                if (in_hdr.msg_len == '0) drop_cnt_d = sat_inc(drop_cnt_q);
                else                      state_d    = RX_META;
            end
            RX_META: if (in_xfer) begin
                meta_src_ip_d   = in_meta.src_ip;
                meta_dst_ip_d   = in_meta.dst_ip;
                meta_src_port_d = in_meta.src_port;
                meta_dst_port_d = in_meta.dst_port;
                meta_len_d      = in_meta.data_length;
                meta_ts_d       = in_meta.timestamp;
                if (len_reject || port_reject) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = (data_flits == '0) ? RX_HDR : DRAIN;
                end else begin
                    state_d = TX_HDR;
                end
            end
            TX_HDR: if (out_xfer) state_d = TX_META;
            TX_META: if (out_xfer) begin
                if (data_flits == '0) begin
                    echo_cnt_d = sat_inc(echo_cnt_q);
                    state_d    = RX_HDR;
                end else begin
                    state_d = PASS;
                end
            end
            PASS, DRAIN: if (in_xfer) begin
                if (flit_cnt_inc == data_flits) begin
                    if (state_q == PASS) echo_cnt_d = sat_inc(echo_cnt_q);
                    flit_cnt_d = '0;
                    state_d    = RX_HDR;
                end else begin
                    flit_cnt_d = flit_cnt_inc;
                end
            end
            default: state_d = RX_HDR;
        endcase
    end

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RX_HDR;
            hdr_msg_len_q   <= '0;
            hdr_pkt_id_q    <= '0;
            hdr_ts_q        <= '0;
            meta_src_ip_q   <= '0;
            meta_dst_ip_q   <= '0;
            meta_src_port_q <= '0;
            meta_dst_port_q <= '0;
            meta_len_q      <= '0;
            meta_ts_q       <= '0;
            flit_cnt_q      <= '0;
            echo_cnt_q      <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            hdr_msg_len_q   <= hdr_msg_len_d;
            hdr_pkt_id_q    <= hdr_pkt_id_d;
            hdr_ts_q        <= hdr_ts_d;
            meta_src_ip_q   <= meta_src_ip_d;
            meta_dst_ip_q   <= meta_dst_ip_d;
            meta_src_port_q <= meta_src_port_d;
            meta_dst_port_q <= meta_dst_port_d;
            meta_len_q      <= meta_len_d;
            meta_ts_q       <= meta_ts_d;
            flit_cnt_q      <= flit_cnt_d;
            echo_cnt_q      <= echo_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign udp_app_in_noc0_ctovr_rdy   = in_rdy;
    assign udp_app_out_noc0_vrtoc_val  = out_val;
    assign udp_app_out_noc0_vrtoc_data = out_data;
    assign echo_cnt                    = echo_cnt_q;
    assign drop_cnt                    = drop_cnt_q;
    assign busy                        = (state_q != RX_HDR);

endmodule

// File: tb/tb_udp_echo_app_filter.sv
// Bench for udp_echo_app_filter: three instances (plain, port filter 7,
// 2-bit counters) driven one at a time, checked against a packet-level model.
`timescale 1ns/1ps

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 256
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif

module tb_udp_echo_app_filter;

    typedef logic [255:0] flit_t;

    typedef struct packed {
        logic [21:0] msg_len;
        logic [15:0] pkt_id;
        logic [63:0] hts;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] dl;
        logic [63:0] mts;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_val = 3'b000;
    logic [2:0]  out_rdy = 3'b111;
    flit_t       in_data = '0;
    logic [7:0]  dst_x = 8'h12;
    logic [7:0]  dst_y = 8'h34;
    wire  [2:0]  in_rdy, out_val, busy;
    flit_t       od0, od1, od2;
    wire  [31:0] echo0, drop0, echo1, drop1;
    wire  [1:0]  echo2, drop2;

    int      total = 0;
    int      bad = 0;
    int      p_srcx[3] = '{3, 255, 3};
    int      p_srcy[3] = '{5, 255, 5};
    int      p_filt[3] = '{-1, 7, -1};
    longint  p_cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};
    longint  echo_exp[3] = '{0, 0, 0};
    longint  drop_exp[3] = '{0, 0, 0};
    flit_t   q0[$], q1[$], q2[$], log0[$];
    flit_t   held[3];
    bit      held_v[3] = '{0, 0, 0};
    bit      bp_en[3] = '{0, 0, 0};
    bit      pat[4] = '{1, 0, 0, 1};
    int      ph = 0;

    always #5 clk = ~clk;

    udp_echo_app_filter #(.SRC_X(3), .SRC_Y(5), .MAX_DATA_LEN(1500), .FILTER_PORT(-1), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst),
        .noc0_ctovr_udp_app_in_val(in_val[0]), .noc0_ctovr_udp_app_in_data(in_data),
        .udp_app_in_noc0_ctovr_rdy(in_rdy[0]), .udp_app_out_noc0_vrtoc_val(out_val[0]),
        .udp_app_out_noc0_vrtoc_data(od0), .noc0_vrtoc_udp_app_out_rdy(out_rdy[0]),
        .src_udp_app_out_dst_x(dst_x), .src_udp_app_out_dst_y(dst_y),
        .echo_cnt(echo0), .drop_cnt(drop0), .busy(busy[0]));

    udp_echo_app_filter #(.FILTER_PORT(7)) u1 (
        .clk(clk), .rst(rst),
        .noc0_ctovr_udp_app_in_val(in_val[1]), .noc0_ctovr_udp_app_in_data(in_data),
        .udp_app_in_noc0_ctovr_rdy(in_rdy[1]), .udp_app_out_noc0_vrtoc_val(out_val[1]),
        .udp_app_out_noc0_vrtoc_data(od1), .noc0_vrtoc_udp_app_out_rdy(out_rdy[1]),
        .src_udp_app_out_dst_x(dst_x), .src_udp_app_out_dst_y(dst_y),
        .echo_cnt(echo1), .drop_cnt(drop1), .busy(busy[1]));

    udp_echo_app_filter #(.SRC_X(3), .SRC_Y(5), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst),
        .noc0_ctovr_udp_app_in_val(in_val[2]), .noc0_ctovr_udp_app_in_data(in_data),
        .udp_app_in_noc0_ctovr_rdy(in_rdy[2]), .udp_app_out_noc0_vrtoc_val(out_val[2]),
        .udp_app_out_noc0_vrtoc_data(od2), .noc0_vrtoc_udp_app_out_rdy(out_rdy[2]),
        .src_udp_app_out_dst_x(dst_x), .src_udp_app_out_dst_y(dst_y),
        .echo_cnt(echo2), .drop_cnt(drop2), .busy(busy[2]));

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flit(input string name, input flit_t act, input flit_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic flit_t get_out(input int i);
        case (i)
            0: return od0;
            1: return od1;
            default: return od2;
        endcase
    endfunction

    function automatic longint get_echo(input int i);
        case (i)
            0: return longint'(echo0);
            1: return longint'(echo1);
            default: return longint'(echo2);
        endcase
    endfunction

    function automatic longint get_drop(input int i);
        case (i)
            0: return longint'(drop0);
            1: return longint'(drop1);
            default: return longint'(drop2);
        endcase
    endfunction

    task automatic exp_push(input int i, input flit_t f);
        case (i)
            0: q0.push_back(f);
            1: q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    function automatic int exp_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic exp_pop(input int i, output flit_t f);
        case (i)
            0: f = q0.pop_front();
            1: f = q1.pop_front();
            default: f = q2.pop_front();
        endcase
    endtask

    function automatic longint sat(input longint v, input int i);
        return (v >= p_cmax[i]) ? v : v + 1;
    endfunction

    function automatic flit_t rand_flit();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Incoming header carries junk in every field the tile must regenerate.
    function automatic flit_t mk_in_hdr(input pkt_t p);
        flit_t f;
        f = '0;
        f[255:248] = 8'h55;  f[247:240] = 8'h66; f[239:236] = 4'h3;
        f[235:214] = p.msg_len; f[213:206] = 8'h33;
        f[205:198] = 8'h77;  f[197:190] = 8'h88; f[189:186] = 4'h5;
        f[185:178] = 8'h09;  f[177:162] = p.pkt_id; f[161:98] = p.hts;
        f[95:0] = {$urandom, $urandom, $urandom};
        return f;
    endfunction

    function automatic flit_t mk_in_meta(input pkt_t p);
        flit_t f;
        f = '0;
        f[255:224] = p.sip; f[223:192] = p.dip; f[191:176] = p.sp; f[175:160] = p.dp;
        f[159:144] = p.dl;  f[143:80] = p.mts;
        f[79:0] = {16'hBEEF, $urandom, $urandom};
        return f;
    endfunction

    function automatic flit_t mk_out_hdr(input pkt_t p, input int i);
        flit_t f;
        f = '0;
        f[255:248] = dst_x; f[247:240] = dst_y; f[239:236] = 4'b1000;
        f[235:214] = p.msg_len; f[213:206] = 8'd12;
        f[205:198] = 8'(p_srcx[i]); f[197:190] = 8'(p_srcy[i]); f[189:186] = 4'b1000;
        f[185:178] = 8'd1; f[177:162] = p.pkt_id; f[161:98] = p.hts;
        return f;
    endfunction

    function automatic flit_t mk_out_meta(input pkt_t p);
        flit_t f;
        f = '0;
        f[255:224] = p.dip; f[223:192] = p.sip; f[191:176] = p.dp; f[175:160] = p.sp;
        f[159:144] = p.dl;  f[143:80] = p.mts;
        return f;
    endfunction

    // ---------------- compare process ----------------
    task automatic mon_one(input int i);
        flit_t d, e;
        d = get_out(i);
        if (rst) begin
            held_v[i] = 0;
            return;
        end
        if (out_val[i]) begin
            if (held_v[i]) chk_flit($sformatf("stall_hold%0d", i), d, held[i]);
            if (in_rdy[i]) check($sformatf("pass_rdy%0d", i), 64'(out_rdy[i]), 64'd1);
            if (out_rdy[i]) begin
                if (exp_size(i) == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out%0d: got %h expected no output", i, d);
                end else begin
                    exp_pop(i, e);
                    chk_flit($sformatf("out%0d", i), d, e);
                end
                if (i == 0) log0.push_back(d);
                held_v[i] = 0;
            end else begin
                held[i] = d;
                held_v[i] = 1;
            end
        end else if (held_v[i]) begin
            total++; bad++;
            $display("FAIL stall_val%0d: got valid 0 expected 1 while stalled", i);
            held_v[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) mon_one(i);
    end

    // Output ready: always high, or the 1,0,0,1 pattern while backpressure is on.
    initial begin
        forever begin
            @(posedge clk); #1;
            ph++;
            for (int i = 0; i < 3; i++) out_rdy[i] = bp_en[i] ? pat[ph % 4] : 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic send_flits(input int idx, input flit_t fl[$]);
        foreach (fl[k]) begin
            bit ok;
            int t;
            in_val[idx] = 1'b1;
            in_data = fl[k];
            ok = 0;
            t = 0;
            while (!ok && t < 100) begin
                @(negedge clk);
                ok = in_rdy[idx];
                @(posedge clk); #1;
                t++;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL send_timeout%0d: got no ready after %0d cycles expected ready", idx, t);
            end
        end
        in_val[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy[idx] || exp_size(idx) != 0) && t < 300);
        if (t >= 300) begin
            total++; bad++;
            $display("FAIL idle_timeout%0d: got busy=%0d pending=%0d expected idle", idx, busy[idx], exp_size(idx));
        end
        @(posedge clk); #1;
    endtask

    // Model: decide echo/drop from the packet rules, queue expected output.
    task automatic build_pkt(input int idx, input pkt_t p, output flit_t fin[$]);
        bit drop;
        int nd;
        fin = {};
        fin.push_back(mk_in_hdr(p));
        if (p.msg_len == 0) begin
            drop = 1;
        end else begin
            fin.push_back(mk_in_meta(p));
            nd = int'(p.msg_len) - 1;
            for (int d = 0; d < nd; d++) fin.push_back(rand_flit());
            drop = (int'(p.dl) > 1500) || (p_filt[idx] != -1 && int'(p.dp) != p_filt[idx]);
        end
        if (drop) begin
            drop_exp[idx] = sat(drop_exp[idx], idx);
        end else begin
            exp_push(idx, mk_out_hdr(p, idx));
            exp_push(idx, mk_out_meta(p));
            for (int k = 2; k < fin.size(); k++) exp_push(idx, fin[k]);
            echo_exp[idx] = sat(echo_exp[idx], idx);
        end
    endtask

    task automatic run_pkt(input int idx, input pkt_t p, input string name);
        flit_t fin[$];
        build_pkt(idx, p, fin);
        send_flits(idx, fin);
        wait_idle(idx);
        check({name, "_echo"}, 64'(get_echo(idx)), 64'(echo_exp[idx]));
        check({name, "_drop"}, 64'(get_drop(idx)), 64'(drop_exp[idx]));
        $display("pkt %s inst=%0d msg_len=%0d dl=%0d dp=%0d echo=%0d drop=%0d",
                 name, idx, p.msg_len, p.dl, p.dp, get_echo(idx), get_drop(idx));
    endtask

    function automatic pkt_t mk_pkt(input int ml, input int dl, input int sp, input int dp);
        pkt_t p;
        p.msg_len = 22'(ml);
        p.pkt_id  = 16'($urandom);
        p.hts     = {$urandom, $urandom};
        p.sip     = 32'h0A00_0001;
        p.dip     = 32'h0A00_0002;
        p.sp      = 16'(sp);
        p.dp      = 16'(dp);
        p.dl      = 16'(dl);
        p.mts     = {$urandom, $urandom};
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        flit_t fin[$], part[$];
        pkt_t  p;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_val%0d", i), 64'(out_val[i]), 64'd0);
            check($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
            check($sformatf("rst_echo%0d", i), 64'(get_echo(i)), 64'd0);
            check($sformatf("rst_drop%0d", i), 64'(get_drop(i)), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("rdy_after_rst%0d", i), 64'(in_rdy[i]), 64'd1);
        @(posedge clk); #1;

        // Basic echo with literal pins on the observed output
        run_pkt(0, mk_pkt(4, 100, 1234, 7), "echo");
        check("log_size", 64'(log0.size()), 64'd5);
        if (log0.size() >= 2) begin
            check("lit_msg_len", 64'(log0[0][235:214]), 64'd4);
            check("lit_msg_type", 64'(log0[0][213:206]), 64'd12);
            check("lit_src_ip", 64'(log0[1][255:224]), 64'h0A00_0002);
            check("lit_dst_ip", 64'(log0[1][223:192]), 64'h0A00_0001);
            check("lit_src_port", 64'(log0[1][191:176]), 64'd7);
            check("lit_dst_port", 64'(log0[1][175:160]), 64'd1234);
        end
        check("lit_echo1", 64'(echo0), 64'd1);

        // Backpressure
        bp_en[0] = 1;
        run_pkt(0, mk_pkt(4, 100, 1234, 7), "backpressure");
        bp_en[0] = 0;
        check("lit_echo2", 64'(echo0), 64'd2);

        // Oversize drop-and-drain, then a normal packet
        run_pkt(0, mk_pkt(6, 1501, 1234, 7), "oversize");
        check("lit_drop1", 64'(drop0), 64'd1);
        run_pkt(0, mk_pkt(3, 1500, 99, 80), "after_oversize");
        check("lit_echo3", 64'(echo0), 64'd3);

        // Port filter
        run_pkt(1, mk_pkt(3, 64, 1234, 8), "filter_drop");
        check("lit_fdrop", 64'(drop1), 64'd1);
        run_pkt(1, mk_pkt(3, 64, 1234, 7), "filter_pass");
        check("lit_fecho", 64'(echo1), 64'd1);
        run_pkt(1, mk_pkt(1, 0, 5, 8), "filter_drop_nodata");

        // Edge cases
        run_pkt(0, mk_pkt(1, 0, 1, 2), "no_data");
        check("lit_echo4", 64'(echo0), 64'd4);
        run_pkt(0, mk_pkt(0, 0, 1, 2), "zero_len");
        check("lit_drop2", 64'(drop0), 64'd2);
        run_pkt(0, mk_pkt(2, 10, 1, 2), "after_zero");

        // Asynchronous reset in the middle of the pass-through phase
        build_pkt(0, mk_pkt(10, 500, 1, 2), fin);
        part = fin[0:3];
        send_flits(0, part);
        @(posedge clk); #3;
        in_val[0] = 1'b1;
        in_data = fin[4];
        #1;
        check("pre_rst_val", 64'(out_val[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("async_val", 64'(out_val[0]), 64'd0);
        check("async_busy", 64'(busy[0]), 64'd0);
        check("async_echo", 64'(echo0), 64'd0);
        check("async_drop", 64'(drop0), 64'd0);
        check("async_echo1", 64'(echo1), 64'd0);
        in_val[0] = 1'b0;
        q0 = {}; q1 = {}; q2 = {};
        for (int i = 0; i < 3; i++) begin
            echo_exp[i] = 0;
            drop_exp[i] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_pkt(0, mk_pkt(3, 20, 4, 5), "post_rst");

        // Saturation with 2-bit counters
        for (int k = 0; k < 5; k++) run_pkt(2, mk_pkt(2, 8, 100 + k, 200), "sat");
        check("lit_sat", 64'(echo2), 64'd3);
        run_pkt(2, mk_pkt(0, 0, 0, 0), "sat_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_echo_app_filter.md
Name: udp_echo_app_filter

Overview:
- Next-generation UDP echo tile. The control FSM and datapath live in one block.
- Receives UDP RX messages from the NoC: header flit, one metadata flit, then data flits. Returns each as a UDP TX segment with IPs and ports swapped.
- New over the previous echo app: valid/ready handshakes on both sides, an optional destination-port filter, a payload length limit with drop-and-drain, and saturating echo/drop statistics counters.
- Sits between the noc0 ctovr/vrtoc interfaces and the UDP TX engine.

Parameters:
- SRC_X, -1, X coordinate of this tile; written into the out header src_x_coord.
- SRC_Y, -1, Y coordinate of this tile; written into the out header src_y_coord.
- MAX_DATA_LEN, 1500, largest accepted udp data_length in bytes; larger packets are dropped.
- FILTER_PORT, -1, -1 disables filtering; otherwise only packets whose meta dst_port equals FILTER_PORT[15:0] are echoed.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- noc0_ctovr_udp_app_in_val  in  1  input flit valid
- noc0_ctovr_udp_app_in_data  in  `NOC_DATA_WIDTH  input flit
- udp_app_in_noc0_ctovr_rdy  out  1  input flit ready
- udp_app_out_noc0_vrtoc_val  out  1  output flit valid
- udp_app_out_noc0_vrtoc_data  out  `NOC_DATA_WIDTH  output flit
- noc0_vrtoc_udp_app_out_rdy  in  1  output flit ready
- src_udp_app_out_dst_x  in  `XY_WIDTH  destination X for echoed packets
- src_udp_app_out_dst_y  in  `XY_WIDTH  destination Y for echoed packets
- echo_cnt  out  CNT_W  packets fully echoed, saturating
- drop_cnt  out  CNT_W  packets dropped, saturating
- busy  out  1  high whenever the FSM is not in RX_HDR

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to RX_HDR; header, metadata and flit counter registers clear to 0.
  - echo_cnt = 0, drop_cnt = 0, out_val = 0, busy = 0.
  - in_rdy = 1 once reset is released.
- Reset mid-packet discards the packet and counts nothing. Any remaining flits of that packet are then parsed as a new header; upstream guarantees reset is applied only to the whole NoC.
- A transfer occurs on a cycle where val and rdy are both high.

FSM states:
- RX_HDR: in_rdy = 1, out_val = 0. On transfer, store the header flit.
  - If msg_len == 0 (malformed): drop_cnt += 1, stay in RX_HDR.
  - Otherwise go to RX_META.
- RX_META: in_rdy = 1, out_val = 0. On transfer, store the metadata flit and evaluate drop.
  - drop = (data_length > MAX_DATA_LEN) OR (FILTER_PORT != -1 AND dst_port != FILTER_PORT).
  - Data flit count D = msg_len - 1.
  - drop AND D == 0: drop_cnt += 1, go to RX_HDR.
  - drop AND D > 0: drop_cnt += 1, go to DRAIN.
  - No drop: go to TX_HDR.
- TX_HDR: out_val = 1, in_rdy = 0. Output header fields:
  - dst_x/dst_y = port inputs, dst_fbits = PKT_IF_FBITS.
  - src_x/src_y = SRC_X/SRC_Y, src_fbits = PKT_IF_FBITS.
  - msg_type = UDP_TX_SEGMENT, metadata_flits = 1.
  - msg_len, packet_id and timestamp copied from the stored header; all other bits 0.
  - On transfer, go to TX_META.
- TX_META: out_val = 1, in_rdy = 0. Output metadata: src_ip = stored dst_ip, dst_ip = stored src_ip, src_port = stored dst_port, dst_port = stored src_port; data_length and timestamp copied; all other bits 0.
  - On transfer with D == 0: echo_cnt += 1, go to RX_HDR.
  - On transfer with D > 0: go to PASS.
- PASS: combinational pass-through, out_data = in_data, out_val = in_val, in_rdy = out_rdy.
  - Each transfer increments the flit counter.
  - On the transfer of flit D: echo_cnt += 1, clear the counter, go to RX_HDR.
- DRAIN: in_rdy = 1, out_val = 0. Consume D flits, then clear the counter and go to RX_HDR.

Timing and data rules:
- Latency: TX_HDR valid appears the cycle after the metadata transfer. In PASS, data has zero-cycle latency.
- Output flits are held stable while out_val = 1 and out_rdy = 0.
- Counters saturate at all-ones; an increment at saturation holds the value.
- The flit counter is `MSG_LENGTH_WIDTH` wide. Comparisons are unsigned. The msg_len - 1 subtraction is evaluated only when msg_len >= 1.
- FILTER_PORT == -1 is resolved at elaboration; no filter logic is generated in that case.

Test Plan:
- Echo with MAX_DATA_LEN = 1500, filter off:
  - Stimulus: msg_len = 4, src_ip = 0x0A000001, dst_ip = 0x0A000002, ports 1234→7, data_length = 100, followed by 3 data flits.
  - Response: header out with msg_len = 4 and msg_type UDP_TX_SEGMENT; metadata out with src_ip = 0x0A000002, dst_ip = 0x0A000001, src_port = 7, dst_port = 1234; 3 data flits bit-identical; echo_cnt = 1.
- Backpressure: same packet with out_rdy toggling 1,0,0,1 every cycle → no flit lost or duplicated; data is held stable while stalled; in_rdy mirrors out_rdy only in PASS.
- Oversize: data_length = 1501, msg_len = 6 → no output valid ever; 5 flits drained with in_rdy = 1; drop_cnt = 1; next good packet is echoed normally.
- Filter with FILTER_PORT = 7: packet with dst_port = 8 → dropped, drop_cnt = 1; packet with dst_port = 7 → echoed, echo_cnt = 1.
- Edge cases:
  - msg_len = 1, data_length = 0 → only header and metadata are output; echo_cnt = 1.
  - msg_len = 0 → drop_cnt = 1 with no RX_META state.
- Reset and saturation:
  - Assert rst asynchronously mid-PASS → out_val = 0, busy = 0, and counters = 0 immediately, without waiting for a clock edge.
  - With CNT_W = 2, echo 5 packets → echo_cnt stays at 3.
